// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive control slice: register map,
// CTRL/STATUS bit positions, drain FSM states and a STATUS packing helper.
package uart_pkg;

    localparam logic [1:0] UART_RX_REG_CLKDIV = 2'd0;
    localparam logic [1:0] UART_RX_REG_CTRL   = 2'd1;
    localparam logic [1:0] UART_RX_REG_STATUS = 2'd2;
    localparam logic [1:0] UART_RX_REG_DATA   = 2'd3;

    localparam int CTRL_RX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_TH_LSB = 4;
    localparam int CTRL_TH_MSB = 7;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_TIMEOUT   = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic {
        RXC_IDLE,
        RXC_ACK
    } rxc_state_e;

    function automatic logic [31:0] pack_status(
        input logic       not_empty,
        input logic       full,
        input logic       overrun,
        input logic       timeout,
        input logic [4:0] count
    );
        logic [31:0] s;
        s                    = '0;
        s[ST_NOT_EMPTY]      = not_empty;
        s[ST_FULL]           = full;
        s[ST_OVERRUN]        = overrun;
        s[ST_TIMEOUT]        = timeout;
        s[ST_COUNT_LSB +: 5] = count;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Processor-side register bus of the UART receive controller.
// The CPU side uses the master modport, the controller the slave modport.
interface uart_rx_ctrl_if;

    logic [1:0]  bus_addr;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wr,
        output bus_rd,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wr,
        input  bus_rd,
        input  bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for the UART receive path. A push into a full FIFO
// is accepted only when a pop happens on the same edge.
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    // NOTE: the storage array is deliberately not reset; the pointers and count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // NOTE: non-blocking assignments so every update on this edge reads the pre-edge pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud/enable registers, receiver drain FSM, RX FIFO,
// status and level interrupt. Optional idle timeout: UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] CLK_DIV_RST = 32'd868
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_ctrl_if.slave        bus,
    output logic [31:0]          rxu_clk_div,
    output logic                 rxu_rst,
    output logic                 rxu_irq_en,
    input  logic                 rxu_irq,
    input  logic [7:0]           rxu_data,
    output logic                 rxu_read,
    output logic                 irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rxc_state_e  state_q;
    rxc_state_e  state_d;
    logic        push_req;
    logic        read_d;
    logic        rxu_read_q;

    logic [31:0] clkdiv_q;
    logic        rx_en_q;
    logic        irq_en_q;
    logic        ovr_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;
    logic        irq_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic [CW-1:0] fifo_count;
    logic [4:0]  count5;

    logic        wr_clkdiv;
    logic        wr_ctrl;
    logic        wr_status;
    logic        pop_ok;
    logic        push_ok;
    logic        overrun_set;
    logic        timeout_w;
    logic [31:0] ctrl_w;
    logic        irq_cause;

    assign wr_clkdiv   = bus.bus_wr && (bus.bus_addr == UART_RX_REG_CLKDIV);
    assign wr_ctrl     = bus.bus_wr && (bus.bus_addr == UART_RX_REG_CTRL);
    assign wr_status   = bus.bus_wr && (bus.bus_addr == UART_RX_REG_STATUS);
    assign pop_ok      = bus.bus_rd && (bus.bus_addr == UART_RX_REG_DATA) && !fifo_empty;
    assign push_ok     = push_req && (!fifo_full || pop_ok);
    assign overrun_set = push_req && fifo_full && !pop_ok;
    assign count5      = 5'(fifo_count);

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop_ok),
        .wdata (rxu_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Drain FSM: take one byte per irq, then spend a cycle in ACK while the receiver drops irq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RXC_IDLE;
            rxu_read_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxu_read_q <= read_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        read_d   = 1'b0;
        case (state_q)
            RXC_IDLE: begin
                if (rxu_irq) begin
                    push_req = 1'b1;
                    read_d   = 1'b1;
                    state_d  = RXC_ACK;
                end
            end
            RXC_ACK: begin
                state_d = RXC_IDLE;
            end
            default: state_d = RXC_IDLE;
        endcase
        if (!rx_en_q) begin
            state_d  = RXC_IDLE;
            push_req = 1'b0;
            read_d   = 1'b0;
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    logic [3:0]  th_q;
    logic [3:0]  th_eff;
    logic [31:0] idle_cnt_q;
    logic [31:0] idle_limit;
    logic        idle_clr;
    logic        timeout_q;
    logic        timeout_set;

    assign th_eff      = (th_q == 4'd0) ? 4'd1 : th_q;
    assign idle_limit  = {clkdiv_q[29:0], 2'b00};
    assign idle_clr    = push_ok || pop_ok || fifo_empty;
    assign timeout_set = !idle_clr && (idle_cnt_q != idle_limit) &&
                         (idle_cnt_q + 32'd1 == idle_limit);
    assign timeout_w   = timeout_q;
    assign ctrl_w      = {24'd0, th_q, 2'b00, irq_en_q, rx_en_q};
    assign irq_cause   = ovr_q || (count5 >= {1'b0, th_eff}) || timeout_q;

    // Idle counter stops at the limit so the timeout fires once per idle stretch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            th_q       <= 4'd0;
            idle_cnt_q <= 32'd0;
            timeout_q  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                th_q <= bus.bus_wdata[CTRL_TH_MSB:CTRL_TH_LSB];
            end
            if (idle_clr) begin
                idle_cnt_q <= 32'd0;
            end else if (idle_cnt_q != idle_limit) begin
                idle_cnt_q <= idle_cnt_q + 32'd1;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (wr_status && bus.bus_wdata[ST_TIMEOUT]) begin
                timeout_q <= 1'b0;
            end
        end
    end
`else
    assign timeout_w = 1'b0;
    assign ctrl_w    = {30'd0, irq_en_q, rx_en_q};
    assign irq_cause = ovr_q || !fifo_empty;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (bus.bus_addr)
            UART_RX_REG_CLKDIV: rd_mux = clkdiv_q;
            UART_RX_REG_CTRL:   rd_mux = ctrl_w;
            UART_RX_REG_STATUS: rd_mux = pack_status(!fifo_empty, fifo_full, ovr_q,
                                                     timeout_w, count5);
            UART_RX_REG_DATA:   rd_mux = fifo_empty ? 32'd0 : {24'd0, fifo_head};
            default:            rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkdiv_q <= CLK_DIV_RST;
            rx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            ovr_q    <= 1'b0;
            rdata_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_clkdiv) begin
                clkdiv_q <= bus.bus_wdata;
            end
            if (wr_ctrl) begin
                rx_en_q  <= bus.bus_wdata[CTRL_RX_EN];
                irq_en_q <= bus.bus_wdata[CTRL_IRQ_EN];
            end
            // A new overrun beats a simultaneous W1C.
            if (overrun_set) begin
                ovr_q <= 1'b1;
            end else if (wr_status && bus.bus_wdata[ST_OVERRUN]) begin
                ovr_q <= 1'b0;
            end
            if (bus.bus_rd) begin
                rdata_q <= rd_mux;
            end
            irq_q <= irq_en_q && irq_cause;
        end
    end

    assign bus.bus_rdata = rdata_q;
    assign rxu_clk_div   = clkdiv_q;
    assign rxu_rst       = rst | ~rx_en_q;
    assign rxu_irq_en    = 1'b1;
    assign rxu_read      = rxu_read_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (default build, FIFO depth 8): a queue
// model of the register map plus directed byte/bus sequences.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rxu_clk_div;
    logic        rxu_rst;
    logic        rxu_irq_en;
    logic        rxu_irq;
    logic [7:0]  rxu_data;
    logic        rxu_read;
    logic        irq;

    uart_rx_ctrl_if bus_if ();

    uart_rx_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .CLK_DIV_RST (32'd868)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .rxu_clk_div (rxu_clk_div),
        .rxu_rst     (rxu_rst),
        .rxu_irq_en  (rxu_irq_en),
        .rxu_irq     (rxu_irq),
        .rxu_data    (rxu_data),
        .rxu_read    (rxu_read),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-level model: a byte queue plus the software-visible bits.
    logic [7:0]  m_q[$];
    bit          m_ovr;
    bit          m_rx_en;
    bit          m_irq_en;
    logic [31:0] m_clkdiv;

    function automatic void model_reset();
        m_q.delete();
        m_ovr    = 1'b0;
        m_rx_en  = 1'b0;
        m_irq_en = 1'b0;
        m_clkdiv = 32'd868;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] addr);
        int n;
        n = m_q.size();
        case (addr)
            UART_RX_REG_CLKDIV: return m_clkdiv;
            UART_RX_REG_CTRL:   return {30'd0, m_irq_en, m_rx_en};
            UART_RX_REG_STATUS: return 32'(n * 16 + (m_ovr ? 4 : 0) + (n == DEPTH ? 2 : 0) + (n != 0 ? 1 : 0));
            default:            return (n != 0) ? {24'd0, m_q.pop_front()} : 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [1:0] addr, input logic [31:0] d);
        case (addr)
            UART_RX_REG_CLKDIV: m_clkdiv = d;
            UART_RX_REG_CTRL: begin
                m_rx_en  = d[0];
                m_irq_en = d[1];
            end
            UART_RX_REG_STATUS: if (d[2]) m_ovr = 1'b0;
            default: ;
        endcase
    endfunction

    function automatic void model_push(input logic [7:0] d);
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovr = 1'b1;
    endfunction

    // Every-cycle compare: irq follows the previous cycle's cause.
    bit chk_en   = 1'b0;
    bit irq_prev = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("clk_div", rxu_clk_div, m_clkdiv);
            check("rxu_rst", {31'd0, rxu_rst}, {31'd0, rst | ~m_rx_en});
            check("rxu_irq_en", {31'd0, rxu_irq_en}, 32'd1);
            check("irq", {31'd0, irq}, rst ? 32'd0 : {31'd0, irq_prev});
            irq_prev = !rst && m_irq_en && (m_ovr || m_q.size() != 0);
        end
    end

    task automatic bus_cycle(input bit wr, input bit rd, input logic [1:0] addr,
                             input logic [31:0] wdata, input bit push,
                             input logic [7:0] pdata, output logic [31:0] got);
        logic [31:0] exp_rd;
        @(negedge clk);
        bus_if.bus_addr  = addr;
        bus_if.bus_wr    = wr;
        bus_if.bus_rd    = rd;
        bus_if.bus_wdata = wdata;
        if (push) begin
            rxu_data = pdata;
            rxu_irq  = 1'b1;
        end
        @(posedge clk);
        #1;
        bus_if.bus_wr = 1'b0;
        bus_if.bus_rd = 1'b0;
        exp_rd = rd ? model_read(addr) : 32'd0;
        if (wr) model_write(addr, wdata);
        if (push) begin
            model_push(pdata);
            check("rxu_read_hi", {31'd0, rxu_read}, 32'd1);
            rxu_irq = 1'b0;
        end
        got = bus_if.bus_rdata;
        if (rd) check($sformatf("rdata_a%0d", addr), got, exp_rd);
        if (push) begin
            @(posedge clk);
            #1;
            check("rxu_read_lo", {31'd0, rxu_read}, 32'd0);
        end
    endtask

    task automatic wr_reg(input logic [1:0] addr, input logic [31:0] d);
        logic [31:0] unused;
        bus_cycle(1'b1, 1'b0, addr, d, 1'b0, 8'h00, unused);
    endtask

    task automatic rd_reg(input logic [1:0] addr, output logic [31:0] got);
        bus_cycle(1'b0, 1'b1, addr, 32'd0, 1'b0, 8'h00, got);
    endtask

    task automatic push_byte(input logic [7:0] d);
        logic [31:0] unused;
        bus_cycle(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, d, unused);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        rst              = 1'b1;
        rxu_irq          = 1'b0;
        rxu_data         = 8'h00;
        bus_if.bus_addr  = 2'd0;
        bus_if.bus_wr    = 1'b0;
        bus_if.bus_rd    = 1'b0;
        bus_if.bus_wdata = 32'd0;
        model_reset();
        #1;
        check("rst_rdata", bus_if.bus_rdata, 32'd0);
        check("rst_read", {31'd0, rxu_read}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rxu_rst", {31'd0, rxu_rst}, 32'd1);
        check("rst_clkdiv", rxu_clk_div, 32'd868);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Single byte round trip.
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_reset", got, 32'h0);
        wr_reg(UART_RX_REG_CLKDIV, 32'd16);
        wr_reg(UART_RX_REG_CTRL, 32'h1);
        rd_reg(UART_RX_REG_CLKDIV, got);
        check("clkdiv_16", got, 32'd16);
        push_byte(8'hA5);
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_one", got, 32'h11);
        rd_reg(UART_RX_REG_DATA, got);
        check("data_a5", got, 32'hA5);
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_empty", got, 32'h00);
        rd_reg(UART_RX_REG_DATA, got);
        check("data_empty", got, 32'h00);

        // Overflow by one byte.
        for (int i = 1; i <= 9; i++) push_byte(8'(i));
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_ovr", got, 32'h87);
        for (int i = 1; i <= 8; i++) begin
            rd_reg(UART_RX_REG_DATA, got);
            check("data_seq", got, 32'(i));
        end
        rd_reg(UART_RX_REG_DATA, got);
        check("data_9th", got, 32'h00);
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_sticky", got, 32'h04);
        wr_reg(UART_RX_REG_STATUS, 32'h4);
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_w1c", got, 32'h00);

        // Push and pop together while full.
        for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
        bus_cycle(1'b0, 1'b1, UART_RX_REG_DATA, 32'd0, 1'b1, 8'h18, got);
        check("data_pushpop", got, 32'h10);
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_pushpop", got, 32'h83);
        for (int i = 1; i <= 8; i++) begin
            rd_reg(UART_RX_REG_DATA, got);
            check("data_order", got, 32'(8'h10 + i));
        end

        // New overrun beats simultaneous W1C.
        for (int i = 0; i < 8; i++) push_byte(8'(8'h20 + i));
        bus_cycle(1'b1, 1'b0, UART_RX_REG_STATUS, 32'h4, 1'b1, 8'h28, got);
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_setwins", got, 32'h87);
        wr_reg(UART_RX_REG_STATUS, 32'h4);
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_cleared", got, 32'h83);
        for (int i = 0; i < 8; i++) rd_reg(UART_RX_REG_DATA, got);

        // Level interrupt.
        wr_reg(UART_RX_REG_CTRL, 32'h3);
        push_byte(8'h33);
        check("irq_up", {31'd0, irq}, 32'd1);
        wr_reg(UART_RX_REG_STATUS, 32'h4);
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_w1c_noop", got, 32'h11);
        rd_reg(UART_RX_REG_DATA, got);
        check("data_33", got, 32'h33);
        check("irq_still", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1;
        check("irq_down", {31'd0, irq}, 32'd0);

        // Unused CTRL bits read as zero.
        wr_reg(UART_RX_REG_CTRL, 32'hF3);
        rd_reg(UART_RX_REG_CTRL, got);
        check("ctrl_mask", got, 32'h3);

        // Disabling the receiver keeps the FIFO contents.
        push_byte(8'h41);
        push_byte(8'h42);
        wr_reg(UART_RX_REG_CTRL, 32'h2);
        check("rxen_rxu_rst", {31'd0, rxu_rst}, 32'd1);
        rd_reg(UART_RX_REG_STATUS, got);
        check("rxen_keep", got, 32'h21);
        wr_reg(UART_RX_REG_CTRL, 32'h3);
        rd_reg(UART_RX_REG_DATA, got);
        check("data_41", got, 32'h41);

        // Asynchronous reset while a byte is being acknowledged.
        @(negedge clk);
        rxu_data = 8'h55;
        rxu_irq  = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_read", {31'd0, rxu_read}, 32'd1);
        #2;
        rst     = 1'b1;
        rxu_irq = 1'b0;
        model_reset();
        #1;
        check("arst_read", {31'd0, rxu_read}, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_rdata", bus_if.bus_rdata, 32'd0);
        check("arst_rxu_rst", {31'd0, rxu_rst}, 32'd1);
        check("arst_clkdiv", rxu_clk_div, 32'd868);
        @(posedge clk);
        #2 rst = 1'b0;
        rd_reg(UART_RX_REG_STATUS, got);
        check("status_after_rst", got, 32'h00);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
